// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
// State and owner encodings plus default widths.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter with zero flag.
// Times the fixed memory latency in WAIT.
module arb_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // load has priority; decrement stops at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between CPU and DMA.
// IDLE -> ISSUE -> WAIT -> DONE with starvation guard.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_LOAD =
    CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] STARVE_MAX =
    CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  starve_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;

  logic starved;
  logic cpu_win;
  logic dma_win;
  logic grant;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic rd_cap;

  assign starved = (starve_q == STARVE_MAX);
  assign cpu_win = cpu_req && !(dma_req && starved);
  assign dma_win = dma_req && !cpu_win;
  assign grant   = (state_q == IDLE) &&
                   (cpu_win || dma_win);

  // state and owner registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // next-state, grant decision and counter control
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    rd_cap   = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          cpu_win: begin
            state_d = ISSUE;
            owner_d = OWN_CPU;
          end
          dma_win: begin
            state_d = ISSUE;
            owner_d = OWN_DMA;
          end
          default: ;
        endcase
      end
      ISSUE: begin
        cnt_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (cnt_zero) begin
          rd_cap  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // consecutive CPU wins while DMA waits, saturating
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (dma_win) begin
        starve_q <= '0;
      end else if (cpu_win && dma_req) begin
        if (!starved) starve_q <= starve_q + 1'b1;
      end else if (!dma_req) begin
        starve_q <= '0;
      end
    end
  end

  // capture the winner's command on grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      we_q    <= cpu_win ? cpu_we    : dma_we;
      addr_q  <= cpu_win ? cpu_addr  : dma_addr;
      wdata_q <= cpu_win ? cpu_wdata : dma_wdata;
    end
  end

  // latch read data for the owner at end of WAIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else if (rd_cap && !we_q) begin
      if (owner_q == OWN_CPU) cpu_rdata_q <= mem_rdata;
      if (owner_q == OWN_DMA) dma_rdata_q <= mem_rdata;
    end
  end

  arb_wait_counter #(
    .W (CNT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign cpu_gnt   = (owner_q == OWN_CPU);
  assign dma_gnt   = (owner_q == OWN_DMA);
  assign cpu_done  = (state_q == DONE) && cpu_gnt;
  assign dma_done  = (state_q == DONE) && dma_gnt;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: timeline reference model,
// directed scenarios, then randomized requesters.
module tb_mem_port_arbiter;

  localparam int ML  = 2;
  localparam int SL  = 2;
  localparam int ML1 = 1;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } rq_t;

  logic        clk;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [63:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_done;
  logic [63:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [63:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_done;
  logic [63:0] dma_rdata;
  logic        mem_en, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  logic        b_cpu_req, b_cpu_we;
  logic [63:0] b_cpu_addr, b_cpu_wdata;
  logic        b_cpu_gnt, b_cpu_done;
  logic [63:0] b_cpu_rdata;
  logic        b_dma_req, b_dma_we;
  logic [63:0] b_dma_addr, b_dma_wdata;
  logic        b_dma_gnt, b_dma_done;
  logic [63:0] b_dma_rdata;
  logic        b_mem_en, b_mem_we;
  logic [63:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_busy;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(
    .ADDR_W(64), .DATA_W(64),
    .MEM_LATENCY(ML), .STARVE_LIMIT(SL)
  ) u_dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done),
    .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(
    .ADDR_W(64), .DATA_W(64),
    .MEM_LATENCY(ML1), .STARVE_LIMIT(4)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we),
    .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_done(b_cpu_done),
    .cpu_rdata(b_cpu_rdata),
    .dma_req(b_dma_req), .dma_we(b_dma_we),
    .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
    .dma_gnt(b_dma_gnt), .dma_done(b_dma_done),
    .dma_rdata(b_dma_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] init_val(
    logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  // ---- memory environment ----
  logic [63:0] env_mem [logic [63:0]];
  int          cyc  = 0;
  int          due0 = -1;
  int          due1 = -1;
  logic [63:0] val0, val1;

  function automatic logic [63:0] env_rd(
    logic [63:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return init_val(a);
  endfunction

  always @(negedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr] = mem_wdata;
      else begin
        due0 = cyc + ML;
        val0 = env_rd(mem_addr);
      end
    end
    mem_rdata = (cyc == due0) ? val0
                              : {$urandom, $urandom};
    if (b_mem_en && !b_mem_we) begin
      due1 = cyc + ML1;
      val1 = init_val(b_mem_addr);
    end
    b_mem_rdata = (cyc == due1) ? val1
                                : {$urandom, $urandom};
    cyc++;
  end

  // ---- reference model (transaction timeline) ----
  // m_p: cycles into the current access, 0 = idle;
  // 1 = strobe cycle, ML+2 = completion cycle.
  int          m_p, m_own, m_starve;
  logic        m_we;
  logic [63:0] m_addr, m_wdata, m_rval;
  logic [63:0] m_maddr, m_mwdata;
  logic [63:0] m_cpu_rd, m_dma_rd;
  logic [63:0] ref_mem [logic [63:0]];

  function automatic logic [63:0] ref_rd(
    logic [63:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  task automatic model_reset();
    m_p = 0; m_own = 0; m_starve = 0;
    m_we = 0; m_addr = 0; m_wdata = 0; m_rval = 0;
    m_maddr = 0; m_mwdata = 0;
    m_cpu_rd = 0; m_dma_rd = 0;
  endtask

  task automatic model_step();
    bit cw, dw;
    if (m_p == 0) begin
      cw = cpu_req && !(dma_req && m_starve == SL);
      dw = dma_req && !cw;
      if (dw) m_starve = 0;
      else if (cw && dma_req) begin
        if (m_starve < SL) m_starve++;
      end else if (!dma_req) m_starve = 0;
      if (cw || dw) begin
        m_own   = cw ? 1 : 2;
        m_we    = cw ? cpu_we : dma_we;
        m_addr  = cw ? cpu_addr : dma_addr;
        m_wdata = cw ? cpu_wdata : dma_wdata;
        m_maddr  = m_addr;
        m_mwdata = m_wdata;
        if (m_we) ref_mem[m_addr] = m_wdata;
        else m_rval = ref_rd(m_addr);
        m_p = 1;
      end
    end else if (m_p == ML + 1) begin
      if (!m_we) begin
        if (m_own == 1) m_cpu_rd = m_rval;
        else m_dma_rd = m_rval;
      end
      m_p++;
    end else if (m_p == ML + 2) begin
      m_p = 0;
      m_own = 0;
    end else begin
      m_p++;
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("busy", busy, m_p != 0);
    chk("mem_en", mem_en, m_p == 1);
    chk("mem_we", mem_we, m_p == 1 && m_we);
    chk("mem_addr", mem_addr, m_maddr);
    chk("mem_wdata", mem_wdata, m_mwdata);
    chk("cpu_gnt", cpu_gnt, m_own == 1);
    chk("dma_gnt", dma_gnt, m_own == 2);
    chk("cpu_done", cpu_done,
        m_p == ML + 2 && m_own == 1);
    chk("dma_done", dma_done,
        m_p == ML + 2 && m_own == 2);
    chk("cpu_rdata", cpu_rdata, m_cpu_rd);
    chk("dma_rdata", dma_rdata, m_dma_rd);
    chk("gnt_overlap", cpu_gnt & dma_gnt, 0);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  function automatic rq_t new_op();
    rq_t n;
    n.req   = 1'b1;
    n.we    = 1'($urandom_range(1, 0));
    n.addr  = 64'($urandom_range(31, 0)) << 3;
    n.wdata = {$urandom, $urandom};
    return n;
  endfunction

  function automatic rq_t policy(rq_t r, bit done,
                                 bit gnt);
    rq_t n = r;
    if (done) begin
      if ($urandom_range(1, 0) == 0) n.req = 1'b0;
      else n = new_op();
    end else if (!r.req) begin
      if ($urandom_range(2, 0) == 0) n = new_op();
    end else if (gnt) begin
      if ($urandom_range(3, 0) == 0) begin
        n.addr  = {$urandom, $urandom};
        n.wdata = {$urandom, $urandom};
        n.we    = ~r.we;
      end
      if ($urandom_range(7, 0) == 0) n.req = 1'b0;
    end
    return n;
  endfunction

  int          k, last, en_cnt;
  bit          got;
  int          exp_own [6];
  logic [63:0] b_list [4];
  bit          cd, cg, dd, dg;

  initial begin
    reset_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    b_cpu_req = 0; b_cpu_we = 0;
    b_cpu_addr = 0; b_cpu_wdata = 0;
    b_dma_req = 0; b_dma_we = 0;
    b_dma_addr = 0; b_dma_wdata = 0;
    env_mem[64'h100] = 64'hDEAD_BEEF;
    ref_mem[64'h100] = 64'hDEAD_BEEF;
    model_reset();

    // reset state
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
    tick();

    // single CPU read of 0x100
    cpu_req = 1; cpu_we = 0; cpu_addr = 64'h100;
    en_cnt = 0; got = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (mem_en) begin
        en_cnt++;
        chk("rd_mem_addr", mem_addr, 64'h100);
      end
      if (cpu_done) begin
        chk("rd_latency", t, ML + 2);
        chk("rd_data", cpu_rdata, 64'hDEAD_BEEF);
        cpu_req = 0;
        got = 1;
        break;
      end
    end
    chk("rd_done_seen", got, 1);
    chk("rd_en_pulses", en_cnt, 1);
    tick();

    // DMA write 0x1234 to 0x40
    dma_req = 1; dma_we = 1;
    dma_addr = 64'h40; dma_wdata = 64'h1234;
    en_cnt = 0; got = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (mem_en) begin
        en_cnt++;
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 64'h40);
        chk("wr_mem_wdata", mem_wdata, 64'h1234);
      end
      if (dma_done) begin
        chk("wr_dma_rdata", dma_rdata, 0);
        dma_req = 0; dma_we = 0;
        got = 1;
        break;
      end
    end
    chk("wr_done_seen", got, 1);
    chk("wr_en_pulses", en_cnt, 1);
    tick();

    // both requesting continuously
    exp_own = '{1, 1, 2, 1, 1, 2};
    cpu_req = 1; cpu_we = 0; cpu_addr = 64'h8;
    dma_req = 1; dma_we = 0; dma_addr = 64'h10;
    k = 0;
    for (int t = 1; t <= 6 * (ML + 3) + 10; t++) begin
      tick();
      if (cpu_done || dma_done) begin
        chk("grant_order", cpu_done ? 1 : 2,
            exp_own[k]);
        k++;
        if (k == 6) begin
          cpu_req = 0;
          dma_req = 0;
          break;
        end
      end
    end
    chk("grant_count", k, 6);
    tick();

    // requester changes its mind after capture
    cpu_req = 1; cpu_we = 0; cpu_addr = 64'h18;
    tick();
    tick();
    cpu_req = 0; cpu_we = 1;
    cpu_addr = 64'hFFF0; cpu_wdata = 64'h55;
    got = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (cpu_done) begin
        chk("drop_rdata", cpu_rdata,
            init_val(64'h18));
        chk("drop_addr", mem_addr, 64'h18);
        got = 1;
        break;
      end
    end
    chk("drop_done_seen", got, 1);
    cpu_we = 0;
    tick();

    // asynchronous reset in the middle of WAIT
    cpu_req = 1; cpu_we = 0; cpu_addr = 64'h20;
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_dma_gnt", dma_gnt, 0);
    chk("rst_cpu_done", cpu_done, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    cpu_req = 0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int t = 0; t < 4; t++) tick();

    // latency-1 instance, back-to-back reads
    b_list = '{64'h200, 64'h208, 64'h210, 64'h218};
    b_cpu_req = 1; b_cpu_addr = b_list[0];
    k = 0; last = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      chk("b_dma_idle", {b_dma_gnt, b_dma_done}, 0);
      if (b_cpu_done) begin
        chk("b2b_rdata", b_cpu_rdata,
            init_val(b_list[k]));
        if (k == 0) chk("b2b_first", t, ML1 + 2);
        else chk("b2b_gap", t - last, ML1 + 3);
        last = t;
        k++;
        if (k < 4) b_cpu_addr = b_list[k];
        else begin
          b_cpu_req = 0;
          break;
        end
      end
    end
    chk("b2b_count", k, 4);
    tick();
    chk("b_busy_end", b_busy, 0);
    chk("b_dma_rdata", b_dma_rdata, 0);
    chk("b_mem_wdata", b_mem_wdata, 0);
    chk("b_mem_we", b_mem_we, 0);
    chk("b_cpu_gnt", b_cpu_gnt, 0);
    chk("b_mem_en", b_mem_en, 0);

    // randomized requesters against the model
    for (int i = 0; i < 800; i++) begin
      cd = (m_p == ML + 2) && (m_own == 1);
      dd = (m_p == ML + 2) && (m_own == 2);
      cg = (m_own == 1);
      dg = (m_own == 2);
      {cpu_req, cpu_we, cpu_addr, cpu_wdata} =
        policy({cpu_req, cpu_we, cpu_addr, cpu_wdata},
               cd, cg);
      {dma_req, dma_we, dma_addr, dma_wdata} =
        policy({dma_req, dma_we, dma_addr, dma_wdata},
               dd, dg);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
